// File: rtl/rx_pkt_sequencer.sv
// RX packet sequencer: pops frame descriptors, screens them, offers good frames
// to the user and releases packet-buffer space for every frame, good or dropped.
module rx_pkt_sequencer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             usr_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             desc_dv,
  input  logic [13:0]      desc_dout,
  output logic             desc_ack,
  output logic             pkt_valid,
  output logic [10:0]      pkt_len,
  input  logic             pkt_done,
  output logic             rel_valid,
  output logic [10:0]      rel_len,
  input  logic             rel_ack,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  // state   | meaning
  // IDLE    | waiting for enable and a queued descriptor; pops it
  // CHECK   | one cycle to screen the latched descriptor
  // DELIVER | good frame offered to the user until pkt_done
  // RELEASE | buffer release offered until rel_ack; then count it
  typedef enum logic [1:0] {IDLE, CHECK, DELIVER, RELEASE} state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  state_t      state_q, state_d;
  logic [13:0] desc_q;
  logic        drop_q;
  logic [10:0] len_q;
  logic        pkt_bad;
  logic        inc_good, inc_drop;

  assign len_q   = desc_q[10:0];
  assign pkt_bad = (|desc_q[13:11]) || (len_q < MIN_L) || (len_q > MAX_L);
  assign busy    = !rst && (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    desc_ack  = 1'b0;
    pkt_valid = 1'b0;
    pkt_len   = '0;
    rel_valid = 1'b0;
    rel_len   = '0;
    inc_good  = 1'b0;
    inc_drop  = 1'b0;
    // Outputs are forced quiet for the whole reset cycle, not just after it.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (enable && desc_dv) begin
            desc_ack = 1'b1;
            state_d  = CHECK;
          end
        end
        CHECK: state_d = pkt_bad ? RELEASE : DELIVER;
        DELIVER: begin
          pkt_valid = 1'b1;
          pkt_len   = len_q;
          if (pkt_done) state_d = RELEASE;
        end
        RELEASE: begin
          rel_valid = 1'b1;
          rel_len   = len_q;
          if (rel_ack) begin
            state_d  = IDLE;
            inc_good = !drop_q;
            inc_drop = drop_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge usr_clk) begin
    if (rst) begin
      state_q <= IDLE;
      desc_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (desc_ack) desc_q <= desc_dout;
      if (state_q == CHECK) drop_q <= pkt_bad;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge usr_clk) begin
    if (rst || cnt_clr) begin
      good_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (inc_good && (good_cnt != '1)) good_cnt <= good_cnt + CNT_W'(1);
      if (inc_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_pkt_sequencer.sv
// Directed bench for rx_pkt_sequencer; a second narrow-counter instance
// shares the stimulus so counter saturation is reachable in a short run.
module tb_rx_pkt_sequencer;

  logic        usr_clk = 1'b0;
  logic        rst, enable, desc_dv, pkt_done, rel_ack, cnt_clr;
  logic [13:0] desc_dout;
  logic        desc_ack, pkt_valid, rel_valid, busy;
  logic [10:0] pkt_len, rel_len;
  logic [15:0] good_cnt, drop_cnt;

  logic        s_desc_ack, s_pkt_valid, s_rel_valid, s_busy;
  logic [10:0] s_pkt_len, s_rel_len;
  logic [1:0]  s_good_cnt, s_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int pv_cnt = 0;

  always #5 usr_clk = ~usr_clk;

  rx_pkt_sequencer dut (
    .usr_clk(usr_clk), .rst(rst), .enable(enable), .desc_dv(desc_dv),
    .desc_dout(desc_dout), .desc_ack(desc_ack), .pkt_valid(pkt_valid),
    .pkt_len(pkt_len), .pkt_done(pkt_done), .rel_valid(rel_valid),
    .rel_len(rel_len), .rel_ack(rel_ack), .cnt_clr(cnt_clr),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  rx_pkt_sequencer #(.CNT_W(2)) dut_sat (
    .usr_clk(usr_clk), .rst(rst), .enable(enable), .desc_dv(desc_dv),
    .desc_dout(desc_dout), .desc_ack(s_desc_ack), .pkt_valid(s_pkt_valid),
    .pkt_len(s_pkt_len), .pkt_done(pkt_done), .rel_valid(s_rel_valid),
    .rel_len(s_rel_len), .rel_ack(rel_ack), .cnt_clr(cnt_clr),
    .good_cnt(s_good_cnt), .drop_cnt(s_drop_cnt), .busy(s_busy)
  );

  always @(posedge usr_clk) cyc++;

  always @(negedge usr_clk) begin
    if (desc_ack === 1'b1) ack_cnt++;
    if (pkt_valid === 1'b1) pv_cnt++;
  end

  task automatic tick;
    @(posedge usr_clk);
    #1;
  endtask

  // Present one descriptor for a single cycle; DUT must be IDLE with enable=1.
  task automatic send_desc(input logic [13:0] d);
    desc_dout = d;
    desc_dv   = 1'b1;
    tick();
    desc_dv   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; desc_dv = 1'b1; desc_dout = 14'h040;
    pkt_done = 1'b0; rel_ack = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    checks++;
    if (desc_ack !== 1'b0 || busy !== 1'b0 || pkt_valid !== 1'b0 || rel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ack=%b busy=%b pv=%b rv=%b expected all 0",
               desc_ack, busy, pkt_valid, rel_valid);
    end
    checks++;
    if (good_cnt !== 16'd0 || drop_cnt !== 16'd0 || pkt_len !== 11'd0 || rel_len !== 11'd0) begin
      errors++;
      $display("FAIL reset_data got good=%0d drop=%0d plen=%0d rlen=%0d expected 0",
               good_cnt, drop_cnt, pkt_len, rel_len);
    end
    enable = 1'b0;
    rst    = 1'b0;
    tick();
    checks++;
    if (desc_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_enable got ack=%b busy=%b expected 0 0", desc_ack, busy);
    end
    desc_dv = 1'b0;
    enable  = 1'b1;
    tick();
  endtask

  task automatic test_good;
    int a0;
    a0 = ack_cnt;
    desc_dout = 14'h040;
    desc_dv   = 1'b1;
    #1;
    checks++;
    if (desc_ack !== 1'b1) begin
      errors++;
      $display("FAIL good_pop got %b expected 1", desc_ack);
    end
    tick();
    desc_dv = 1'b0;
    enable  = 1'b0;
    tick();
    checks++;
    if (pkt_valid !== 1'b1 || pkt_len !== 11'd64 || busy !== 1'b1) begin
      errors++;
      $display("FAIL good_offer got pv=%b len=%0d busy=%b expected 1 64 1", pkt_valid, pkt_len, busy);
    end
    repeat (5) tick();
    checks++;
    if (pkt_valid !== 1'b1 || rel_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_hold got pv=%b rv=%b expected 1 0", pkt_valid, rel_valid);
    end
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    checks++;
    if (rel_valid !== 1'b1 || rel_len !== 11'd64 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_release got rv=%b len=%0d pv=%b expected 1 64 0", rel_valid, rel_len, pkt_valid);
    end
    rel_ack = 1'b1;
    tick();
    rel_ack = 1'b0;
    checks++;
    if (good_cnt !== 16'd1 || busy !== 1'b0 || (ack_cnt - a0) !== 1) begin
      errors++;
      $display("FAIL good_done got good=%0d busy=%b acks=%0d expected 1 0 1",
               good_cnt, busy, ack_cnt - a0);
    end
    enable = 1'b1;
  endtask

  task automatic test_bad_frames;
    logic [13:0] descs [5];
    logic [10:0] lens  [5];
    int          p0;
    descs = '{14'h2040, 14'd59, 14'd1519, 14'd0, 14'd2047};
    lens  = '{11'd64, 11'd59, 11'd1519, 11'd0, 11'd2047};
    p0 = pv_cnt;
    for (int i = 0; i < 5; i++) begin
      send_desc(descs[i]);
      tick();
      checks++;
      if (rel_valid !== 1'b1 || rel_len !== lens[i] || pkt_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad_release[%0d] got rv=%b len=%0d pv=%b expected 1 %0d 0",
                 i, rel_valid, rel_len, pkt_valid, lens[i]);
      end
      rel_ack = 1'b1;
      tick();
      rel_ack = 1'b0;
    end
    checks++;
    if (drop_cnt !== 16'd5 || good_cnt !== 16'd1 || (pv_cnt - p0) !== 0) begin
      errors++;
      $display("FAIL bad_counts got drop=%0d good=%0d pv_cycles=%0d expected 5 1 0",
               drop_cnt, good_cnt, pv_cnt - p0);
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] q [3];
    int          t [3];
    int          idx, n, a0;
    q = '{14'd60, 14'd1518, 14'd100};
    idx = 0; n = 0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    a0 = ack_cnt;
    pkt_done = 1'b1;
    rel_ack  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      desc_dv   = (idx < 3);
      desc_dout = (idx < 3) ? q[idx] : 14'd0;
      #1;
      if (desc_ack === 1'b1 && n < 3) begin
        t[n] = cyc;
        n++;
        idx++;
      end
      tick();
    end
    desc_dv  = 1'b0;
    pkt_done = 1'b0;
    rel_ack  = 1'b0;
    checks++;
    if (n !== 3 || (ack_cnt - a0) !== 3) begin
      errors++;
      $display("FAIL b2b_pops got %0d/%0d expected 3", n, ack_cnt - a0);
    end
    checks++;
    if (n == 3 && ((t[1] - t[0]) !== 4 || (t[2] - t[1]) !== 4)) begin
      errors++;
      $display("FAIL b2b_spacing got %0d %0d expected 4 4", t[1] - t[0], t[2] - t[1]);
    end
    checks++;
    if (good_cnt !== 16'd3 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts got good=%0d drop=%0d busy=%b expected 3 0 0", good_cnt, drop_cnt, busy);
    end
  endtask

  task automatic test_stall;
    int a0, bad;
    send_desc(14'h040);
    tick();
    pkt_done = 1'b1;
    tick();
    pkt_done  = 1'b0;
    desc_dv   = 1'b1;
    desc_dout = 14'h050;
    a0 = ack_cnt;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (rel_valid !== 1'b1 || rel_len !== 11'd64 || busy !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold got %0d bad cycles expected 0", bad);
    end
    checks++;
    if ((ack_cnt - a0) !== 0) begin
      errors++;
      $display("FAIL stall_no_pop got %0d pops expected 0", ack_cnt - a0);
    end
    desc_dv = 1'b0;
    rel_ack = 1'b1;
    tick();
    rel_ack = 1'b0;
    checks++;
    if (good_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got good=%0d busy=%b expected 4 0", good_cnt, busy);
    end
  endtask

  task automatic test_counter_edges;
    checks++;
    if (s_good_cnt !== 2'd3 || s_drop_cnt !== 2'd0) begin
      errors++;
      $display("FAIL sat_reached got good=%0d drop=%0d expected 3 0", s_good_cnt, s_drop_cnt);
    end
    send_desc(14'h040);
    tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    rel_ack  = 1'b1;
    tick();
    rel_ack  = 1'b0;
    checks++;
    if (s_good_cnt !== 2'd3 || good_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sat_hold got narrow=%0d wide=%0d expected 3 5", s_good_cnt, good_cnt);
    end
    send_desc(14'h040);
    tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    rel_ack  = 1'b1;
    cnt_clr  = 1'b1;
    tick();
    rel_ack  = 1'b0;
    cnt_clr  = 1'b0;
    checks++;
    if (good_cnt !== 16'd0 || s_good_cnt !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority got wide=%0d narrow=%0d busy=%b expected 0 0 0",
               good_cnt, s_good_cnt, busy);
    end
  endtask

  task automatic test_reset_mid;
    send_desc(14'h080);
    tick();
    checks++;
    if (pkt_valid !== 1'b1 || pkt_len !== 11'd128) begin
      errors++;
      $display("FAIL rmid_offer got pv=%b len=%0d expected 1 128", pkt_valid, pkt_len);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || pkt_len !== 11'd0) begin
      errors++;
      $display("FAIL rmid_during got pv=%b busy=%b len=%0d expected 0 0 0", pkt_valid, busy, pkt_len);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || rel_valid !== 1'b0 || busy !== 1'b0 || desc_ack !== 1'b0 ||
        pkt_len !== 11'd0 || rel_len !== 11'd0 || good_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_after got pv=%b rv=%b busy=%b ack=%b plen=%0d rlen=%0d good=%0d drop=%0d expected all 0",
               pkt_valid, rel_valid, busy, desc_ack, pkt_len, rel_len, good_cnt, drop_cnt);
    end
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    rel_ack  = 1'b1;
    tick();
    rel_ack  = 1'b0;
    checks++;
    if (rel_valid !== 1'b0 || busy !== 1'b0 || good_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_ignore got rv=%b busy=%b good=%0d expected 0 0 0", rel_valid, busy, good_cnt);
    end
    send_desc(14'h060);
    tick();
    checks++;
    if (pkt_valid !== 1'b1 || pkt_len !== 11'd96) begin
      errors++;
      $display("FAIL rmid_next_offer got pv=%b len=%0d expected 1 96", pkt_valid, pkt_len);
    end
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    rel_ack  = 1'b1;
    tick();
    rel_ack  = 1'b0;
    checks++;
    if (good_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_next_done got good=%0d busy=%b expected 1 0", good_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_frames();
    test_back_to_back();
    test_stall();
    test_counter_edges();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_pkt_sequencer.md
RX_PKT_SEQUENCER -- requirements
Module: rx_pkt_sequencer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60, minimum accepted frame length in bytes.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum accepted frame length in bytes.
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL have port usr_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits popping new descriptors.
REQ-007 SHALL have port desc_dv  input  1  RX descriptor FIFO non-empty; desc_dout valid (first-word-fall-through).
REQ-008 SHALL have port desc_dout  input  14  descriptor: [13] crc_err, [12] overrun, [11] align_err, [10:0] length in bytes.
REQ-009 SHALL have port desc_ack  output  1  single-cycle pop strobe to the descriptor FIFO.
REQ-010 SHALL have port pkt_valid  output  1  good packet offered to the user.
REQ-011 SHALL have port pkt_len  output  11  byte length of the offered packet.
REQ-012 SHALL have port pkt_done  input  1  user finished with the offered packet.
REQ-013 SHALL have port rel_valid  output  1  request to advance the packet-buffer read pointer.
REQ-014 SHALL have port rel_len  output  11  byte count to release.
REQ-015 SHALL have port rel_ack  input  1  buffer accepted the release.
REQ-016 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-017 SHALL have port good_cnt  output  CNT_W  packets delivered.
REQ-018 SHALL have port drop_cnt  output  CNT_W  packets dropped.
REQ-019 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-020 SHALL implement states IDLE, CHECK, DELIVER, RELEASE.
REQ-021 In IDLE with enable=1 and desc_dv=1, SHALL assert desc_ack for exactly one cycle, latch desc_dout on that edge and go to CHECK.
REQ-022 SHALL never assert desc_ack outside IDLE or when desc_dv=0; at most one pop per packet.
REQ-023 In CHECK (one cycle), SHALL classify the packet bad if any of bits [13:11] is set, length < MIN_LEN or length > MAX_LEN; otherwise good.
REQ-024 From CHECK: good -> DELIVER; bad -> RELEASE with the drop flag set.
REQ-025 In DELIVER, SHALL hold pkt_valid=1 and pkt_len = latched length until pkt_done=1 is sampled, then go to RELEASE.
REQ-026 pkt_done outside DELIVER SHALL be ignored.
REQ-027 In RELEASE, SHALL hold rel_valid=1 and rel_len = latched length until rel_ack=1 is sampled.
REQ-028 rel_ack=1 in the first RELEASE cycle SHALL complete the release in that cycle.
REQ-029 On completion of RELEASE, SHALL increment good_cnt (good) or drop_cnt (bad) by 1 and go to IDLE.
REQ-030 Minimum IDLE-to-IDLE time: 4 cycles for a good packet and 3 cycles for a bad one, with zero-wait pkt_done/rel_ack.
REQ-031 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-032 cnt_clr SHALL zero both counters next cycle and takes priority over a coincident increment.
REQ-033 Deasserting enable mid-packet SHALL NOT abort it; the packet completes and IDLE then waits for enable.
REQ-034 Length 0 and length 2047 SHALL be treated as bad and released with their literal rel_len.

Reset
REQ-035 While rst=1: state IDLE; desc_ack, pkt_valid, rel_valid, busy = 0; pkt_len, rel_len = 0; good_cnt, drop_cnt = 0; latched descriptor cleared.
REQ-036 rst asserted mid-packet SHALL abandon the packet with no counter update and no further handshake; a subsequent rel_ack or pkt_done is ignored.

Verification
REQ-037 Good frame: desc_dout=0x040 (64 B), enable=1 -> one desc_ack pulse, pkt_valid with pkt_len=64; pkt_done after 5 cycles -> rel_valid with rel_len=64; rel_ack -> good_cnt=1, IDLE.
REQ-038 Bad frames: 0x2040 (crc_err), length 59, length 1519 -> no pkt_valid; each gives rel_len equal to its length; drop_cnt=3.
REQ-039 Back-to-back: 3 good descriptors queued with zero-wait handshakes -> exactly 3 desc_ack pulses, each spaced >=4 cycles apart; good_cnt=3.
REQ-040 Stall: rel_ack withheld 20 cycles -> rel_valid and rel_len stable throughout, no desc_ack, busy=1.
REQ-041 Counter edges: preload good_cnt to 0xFFFF, deliver a good packet -> stays 0xFFFF; cnt_clr coincident with an increment -> 0.
REQ-042 Reset in DELIVER: rst for 1 cycle -> all outputs 0 next cycle; a later pkt_done is ignored; the next descriptor is processed normally.
